frame_58_tx: RTL

FRAME_58_TX -- requirements
Module: frame_58_tx

---
 rtl/frame_58_tx_pkg.sv | 14 +
 rtl/frame_58_tx_next.sv | 45 ++++
 rtl/shift_reg8.sv | 22 ++
 rtl/frame_58_tx.sv | 84 ++++++++
 4 files changed

// File: rtl/frame_58_tx_pkg.sv
// Shared definitions for the 0x58 framing family: FSM encodings, frame length
// and the default sync byte.
package frame_58_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int unsigned FRAME_BITS   = 16;
  localparam logic [7:0]  SYNC_DEFAULT = 8'h58;

endpackage

// File: rtl/frame_58_tx_next.sv
// Next-state and bit-counter logic for the framer; purely combinational.
module frame_58_tx_next
  import frame_58_tx_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] cnt,
  input  logic       accept,
  output state_t     state_nxt,
  output logic [2:0] cnt_nxt
);

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = 3'd0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (cnt == 3'd7) begin
          state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_SYNC;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      ST_DATA: begin
        if (cnt == 3'd7) begin
          // accept can only be true here on the last payload bit
          state_nxt = accept ? ST_SYNC : ST_IDLE;
        end else begin
          state_nxt = ST_DATA;
          cnt_nxt   = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg8.sv
// 8-bit parallel-load register that shifts toward the MSB; q[7] is the bit on air.
module shift_reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] d,
  output logic [7:0] q
);

  // Load wins over shift so a back-to-back byte can land on the last payload bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 8'h00;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/frame_58_tx.sv
// Serial framer: each accepted byte goes out MSB-first behind an 8-bit sync
// byte, 16 contiguous valid bits per frame, back-to-back frames allowed.
module frame_58_tx
  import frame_58_tx_pkg::*;
#(
  parameter logic [7:0] SYNC = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out,
  output logic       out_valid,
  output logic       busy
);

  // Handshake: a byte is taken on a rising edge where in_valid && in_ready;
  // in_ready depends only on state/cnt, never on in_valid.
  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic       accept;
  logic       shift;
  logic [7:0] payload;

  assign accept = in_valid && in_ready;
  assign shift  = (state == ST_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  frame_58_tx_next u_next (
    .state     (state),
    .cnt       (cnt),
    .accept    (accept),
    .state_nxt (state_nxt),
    .cnt_nxt   (cnt_nxt)
  );

  shift_reg8 u_payload (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .d     (in_data),
    .q     (payload)
  );

  always_comb begin
    in_ready  = 1'b0;
    out       = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SYNC: begin
        out       = SYNC[3'd7 - cnt];
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      ST_DATA: begin
        out       = payload[7];
        out_valid = 1'b1;
        busy      = 1'b1;
        in_ready  = (cnt == 3'd7);
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
